debounce_filter: RTL and testbench

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

---
 rtl/debounce_filter.sv | 138 +++++++++++++
 tb/tb_debounce_filter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/debounce_filter.sv
// Debounce filter: 2-flop synchronizer followed by a 4-state qualification FSM.
// Latency: a clean Raw change shows on Data STABLE_CYCLES+1 edges after its first capture edge.
// No backpressure. Define DEBOUNCE_EDGE_EN to build the Rise/Fall pulse flops; otherwise they are tied to 0.
module debounce_filter #(
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 8
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Raw,
   output logic Data,
   output logic Rise,
   output logic Fall,
   output logic Busy
);

   typedef enum logic [1:0] {
      IDLE_LO = 2'd0,
      WAIT_HI = 2'd1,
      IDLE_HI = 2'd2,
      WAIT_LO = 2'd3
   } state_t;

   // Count value at which the next matching sample is the STABLE_CYCLES-th one.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic             meta_q;
   logic             sync_q;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             data_q, data_d;
   logic             busy_q, busy_d;

   // Two-flop synchronizer; only sync_q is seen by the filter.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= Raw;
         sync_q <= meta_q;
      end
   end

   // Next-state logic: any opposite sample restarts, the STABLE_CYCLES-th matching one accepts.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      case (state_q)
         IDLE_LO: begin
            cnt_d = '0;
            if (sync_q) begin
               state_d = WAIT_HI;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_HI: begin
            if (!sync_q) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
               data_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         IDLE_HI: begin
            cnt_d = '0;
            if (!sync_q) begin
               state_d = WAIT_LO;
               cnt_d   = CNT_W'(1);
            end
         end
         WAIT_LO: begin
            if (sync_q) begin
               state_d = IDLE_HI;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE_LO;
               cnt_d   = '0;
               data_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE_LO;
            cnt_d   = '0;
         end
      endcase
      // Busy is registered from the next state so it drops on the accept edge together with the Data change.
      busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
   end

   // FSM, counter and output registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE_LO;
         cnt_q   <= '0;
         data_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
      end
   end

   assign Data = data_q;
   assign Busy = busy_q;

`ifdef DEBOUNCE_EDGE_EN
   logic rise_q;
   logic fall_q;

   // Edge pulses go high on the same edge that Data takes its new value.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= data_d & ~data_q;
         fall_q <= ~data_d & data_q;
      end
   end

   assign Rise = rise_q;
   assign Fall = fall_q;
`else
   assign Rise = 1'b0;
   assign Fall = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter with STABLE_CYCLES=4.
// Edge e counts from the first edge that captures a new Raw value.
// Rise/Fall expectations follow the DEBOUNCE_EDGE_EN build setting.
module tb_debounce_filter;

`ifdef DEBOUNCE_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset;
   logic Raw;
   logic Data, Rise, Fall, Busy;

   int n_vec  = 0;
   int n_miss = 0;
   int rises, falls, seen_hi;

   debounce_filter #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Raw  (Raw),
      .Data (Data),
      .Rise (Rise),
      .Fall (Fall),
      .Busy (Busy)
   );

   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   initial begin
      Reset = 1'b1;
      Raw   = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_data", Data, 0);
      chk("rst_rise", Rise, 0);
      chk("rst_fall", Fall, 0);
      chk("rst_busy", Busy, 0);
      Reset = 1'b0;
      repeat (3) tick();

      // Clean 0->1: Data and Rise at edge 5, Busy high through edge 4.
      Raw = 1'b1;
      for (int e = 0; e <= 6; e++) begin
         tick();
         chk($sformatf("clean_data_e%0d", e), Data, e >= 5);
         chk($sformatf("clean_rise_e%0d", e), Rise, EDGE && e == 5);
         chk($sformatf("clean_fall_e%0d", e), Fall, 0);
         if (e != 2)
            chk($sformatf("clean_busy_e%0d", e), Busy, e >= 2 && e <= 4);
      end

      // Bounce 1,0,1,0 for 20 cycles then stay low: one Fall at edge 5 after the last low.
      falls = 0;
      for (int i = 0; i < 20; i++) begin
         Raw = (i % 2 == 0);
         tick();
         falls += Fall;
         chk($sformatf("bounce_data_%0d", i), Data, 1);
      end
      for (int e = 1; e <= 7; e++) begin
         tick();
         falls += Fall;
         chk($sformatf("settle_data_e%0d", e), Data, e < 5);
         chk($sformatf("settle_fall_e%0d", e), Fall, EDGE && e == 5);
      end
      chk("bounce_nfall", falls, EDGE ? 1 : 0);

      // 3-cycle pulse: one sample short, never accepted.
      rises = 0;
      seen_hi = 0;
      Raw = 1'b1;
      repeat (3) begin tick(); rises += Rise; seen_hi |= Data; end
      Raw = 1'b0;
      repeat (10) begin tick(); rises += Rise; seen_hi |= Data; end
      chk("short_data_hi", seen_hi, 0);
      chk("short_nrise", rises, 0);
      chk("short_busy_end", Busy, 0);

      // 4-cycle pulse: exactly enough to accept, then qualifies back low.
      rises = 0;
      falls = 0;
      seen_hi = 0;
      Raw = 1'b1;
      repeat (4) begin tick(); rises += Rise; falls += Fall; seen_hi |= Data; end
      Raw = 1'b0;
      repeat (12) begin tick(); rises += Rise; falls += Fall; seen_hi |= Data; end
      chk("exact_data_hi", seen_hi, 1);
      chk("exact_nrise", rises, EDGE ? 1 : 0);
      chk("exact_nfall", falls, EDGE ? 1 : 0);
      chk("exact_data_end", Data, 0);
      chk("exact_busy_end", Busy, 0);

      // Reset in WAIT_HI with cnt=2, then full requalification with Raw held high.
      Raw = 1'b1;
      for (int e = 0; e <= 3; e++) tick();
      chk("abort_busy_pre", Busy, 1);
      #2 Reset = 1'b1;
      #1;
      chk("abort_busy_async", Busy, 0);
      chk("abort_data_async", Data, 0);
      chk("abort_rise_async", Rise, 0);
      chk("abort_fall_async", Fall, 0);
      tick();
      Reset = 1'b0;
      rises = 0;
      for (int e = 0; e <= 6; e++) begin
         tick();
         rises += Rise;
         chk($sformatf("requal_data_e%0d", e), Data, e >= 5);
         chk($sformatf("requal_rise_e%0d", e), Rise, EDGE && e == 5);
      end
      chk("requal_nrise", rises, EDGE ? 1 : 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
